// File: rtl/ex_muldiv_unit_if.sv
// ============================================================================
// Module   : ex_muldiv_unit_if
// Purpose  : EX-stage bus between the ID/EX register and the mul/div unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ex_muldiv_unit_if;
  logic        MulDivE;
  logic [2:0]  funct3E;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] RdE;
  logic        FlushE;
  logic        StallMD;
  logic        BusyMD;
  logic        ValidMD;
  logic [31:0] ResultMD;
  logic [31:0] RdMD;

  modport master (
    output MulDivE, funct3E, RD1E, RD2E, RdE, FlushE,
    input  StallMD, BusyMD, ValidMD, ResultMD, RdMD
  );

  modport slave (
    input  MulDivE, funct3E, RD1E, RD2E, RdE, FlushE,
    output StallMD, BusyMD, ValidMD, ResultMD, RdMD
  );
endinterface

`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
// ============================================================================
// Module   : ex_muldiv_unit
// Purpose  : Iterative radix-2 RV32M multiply/divide unit for the EX stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_muldiv_unit (
  input  wire logic      clk,
  input  wire logic      reset,
  ex_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [31:0] r_opnd;
  logic [63:0] r_acc;
  logic        r_neg;
  logic        r_rem_neg;
  logic [31:0] r_rd;
  logic [31:0] r_result;
  logic        r_valid;

  logic        w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;
  logic        w_div0, w_ovf;
  logic [31:0] w_spec_res;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [63:0] w_div_next;
  logic [63:0] w_acc_next;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_final;

  // Operand signedness: MULHU/DIVU/REMU unsigned; MULHSU signed rs1 only.
  assign w_a_sgn = (bus.funct3E == 3'b001) | ~bus.funct3E[0];
  assign w_b_sgn = (bus.funct3E == 3'b001) | (~bus.funct3E[0] & (bus.funct3E != 3'b010));
  assign w_a_neg = w_a_sgn & bus.RD1E[31];
  assign w_b_neg = w_b_sgn & bus.RD2E[31];
  assign w_a_mag = w_a_neg ? (32'd0 - bus.RD1E) : bus.RD1E;
  assign w_b_mag = w_b_neg ? (32'd0 - bus.RD2E) : bus.RD2E;

  assign w_div0 = bus.funct3E[2] & (bus.RD2E == 32'd0);
  assign w_ovf  = bus.funct3E[2] & ~bus.funct3E[0] &
                  (bus.RD1E == 32'h8000_0000) & (bus.RD2E == 32'hFFFF_FFFF);
  assign w_spec_res = w_div0 ? (bus.funct3E[1] ? bus.RD1E : 32'hFFFF_FFFF)
                             : (bus.funct3E[1] ? 32'd0    : 32'h8000_0000);

  // Multiply: accumulator holds {partial product, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, r_opnd};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[31:1]} : {1'b0, r_acc[63:1]};

  // Divide: accumulator holds {partial remainder, dividend/quotient bits}.
  assign w_rem_sh   = r_acc[63:31];
  assign w_ge       = w_rem_sh >= {1'b0, r_opnd};
  assign w_sub      = w_rem_sh[31:0] - r_opnd;
  assign w_div_next = w_ge ? {w_sub, r_acc[30:0], 1'b1}
                           : {w_rem_sh[31:0], r_acc[30:0], 1'b0};

  assign w_acc_next = r_f3[2] ? w_div_next : w_mul_next;

  assign w_prod = r_neg     ? (64'd0 - w_acc_next)         : w_acc_next;
  assign w_quo  = r_neg     ? (32'd0 - w_acc_next[31:0])   : w_acc_next[31:0];
  assign w_rem  = r_rem_neg ? (32'd0 - w_acc_next[63:32])  : w_acc_next[63:32];

  always_comb begin
    w_final = w_rem;
    case (r_f3)
      3'b000:                 w_final = w_prod[31:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod[63:32];
      3'b100, 3'b101:         w_final = w_quo;
      default:                w_final = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 6'd0;
      r_f3      <= 3'd0;
      r_opnd    <= 32'd0;
      r_acc     <= 64'd0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_rd      <= 32'd0;
      r_result  <= 32'd0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (bus.FlushE) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.MulDivE) begin
              r_f3      <= bus.funct3E;
              r_rd      <= bus.RdE;
              r_cnt     <= 6'd0;
              r_opnd    <= bus.funct3E[2] ? w_b_mag : w_a_mag;
              r_acc     <= {32'd0, bus.funct3E[2] ? w_a_mag : w_b_mag};
              r_neg     <= w_a_neg ^ w_b_neg;
              r_rem_neg <= w_a_neg;
              if (w_div0 | w_ovf) begin
                r_state  <= S_DONE;
                r_result <= w_spec_res;
                r_valid  <= 1'b1;
              end else begin
                r_state <= S_CALC;
              end
            end
          end
          S_CALC: begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd31) begin
              r_state  <= S_DONE;
              r_result <= w_final;
              r_valid  <= 1'b1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.StallMD  = reset & (((r_state == S_IDLE) & bus.MulDivE & ~bus.FlushE) |
                                 (r_state == S_CALC));
  assign bus.BusyMD   = (r_state != S_IDLE);
  assign bus.ValidMD  = r_valid;
  assign bus.ResultMD = r_result;
  assign bus.RdMD     = r_rd;

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Purpose  : Scoreboard bench for ex_muldiv_unit with a behavioural RV32M model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ex_muldiv_unit;

  logic clk;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_fail;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  ex_muldiv_unit_if bus();

  ex_muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Reference model: plain 64-bit / 32-bit arithmetic on the architectural rules.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    int          ia, ib;
    ia = int'(a);
    ib = int'(b);
    sa = (f == 3'b011) ? longint'({32'd0, a}) : longint'(ia);
    sb = (f == 3'b000 || f == 3'b001) ? longint'(ib) : longint'({32'd0, b});
    p  = 64'(sa * sb);
    case (f)
      3'b000: return p[31:0];
      3'b001, 3'b010, 3'b011: return p[63:32];
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: every ValidMD pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && bus.ValidMD === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: actual ValidMD=1 required ValidMD=0 (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("result", bus.ResultMD, e.res);
        chk("rd_tag", bus.RdMD, e.rd);
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Issue one op in the current IDLE cycle and hold it (as ID/EX would) until DONE.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] rd);
    int   t;
    int   stalls;
    bit   got;
    bit   sp;
    exp_t e;
    @(posedge clk);
    #1;
    bus.MulDivE = 1'b1;
    bus.funct3E = f;
    bus.RD1E    = a;
    bus.RD2E    = b;
    bus.RdE     = rd;
    t      = cyc;
    sp     = is_special(f, a, b);
    e.res  = ref_res(f, a, b);
    e.rd   = rd;
    e.cyc  = t + (sp ? 1 : 33);
    sb_q.push_back(e);
    stalls = 0;
    got    = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (bus.StallMD === 1'b1) stalls++;
      if (bus.ValidMD === 1'b1) begin
        got = 1'b1;
        chk("busy_in_done", 32'(bus.BusyMD), 32'd1);
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("stall_cycles", 32'(stalls), sp ? 32'd1 : 32'd33);
    if (!got) sb_q.delete();
  endtask

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    bus.MulDivE = 1'b1;
    bus.funct3E = 3'b000;
    bus.RD1E    = 32'd0;
    bus.RD2E    = 32'd0;
    bus.RdE     = 32'd0;
    bus.FlushE  = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid",  32'(bus.ValidMD), 32'd0);
    chk("reset_result", bus.ResultMD, 32'd0);
    chk("reset_rd",     bus.RdMD, 32'd0);
    chk("reset_busy",   32'(bus.BusyMD), 32'd0);
    chk("reset_stall",  32'(bus.StallMD), 32'd0);
    bus.MulDivE = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Directed ops; chained calls run back-to-back with MulDivE held through DONE.
    run_op(3'b000, 32'hFFFF_FFF9, 32'h0000_0003, 32'd5);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'd6);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd8);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'd9);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'd10);
    run_op(3'b101, 32'd100, 32'd7, 32'd11);
    run_op(3'b111, 32'd100, 32'd7, 32'd12);
    run_op(3'b101, 32'd5, 32'd0, 32'd13);
    run_op(3'b110, 32'd5, 32'd0, 32'd14);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd15);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd16);
    run_op(3'b000, 32'd1234, 32'd5678, 32'd17);
    run_op(3'b101, 32'hDEAD_BEEF, 32'd3, 32'd18);
    @(posedge clk);
    #1 bus.MulDivE = 1'b0;

    // Flush in CALC cycle 10 (counter = 10), no result may appear.
    @(posedge clk);
    #1;
    bus.MulDivE = 1'b1;
    bus.funct3E = 3'b000;
    bus.RD1E    = 32'd99;
    bus.RD2E    = 32'd77;
    bus.RdE     = 32'd21;
    repeat (11) @(posedge clk);
    #1;
    bus.FlushE  = 1'b1;
    bus.MulDivE = 1'b0;
    @(posedge clk);
    #1;
    bus.FlushE = 1'b0;
    chk("flush_stall", 32'(bus.StallMD), 32'd0);
    chk("flush_busy",  32'(bus.BusyMD), 32'd0);
    // Flush overrides a start in the same IDLE cycle.
    bus.MulDivE = 1'b1;
    bus.FlushE  = 1'b1;
    #1 chk("flush_start_stall", 32'(bus.StallMD), 32'd0);
    @(posedge clk);
    #1;
    bus.MulDivE = 1'b0;
    bus.FlushE  = 1'b0;
    chk("flush_start_busy", 32'(bus.BusyMD), 32'd0);
    repeat (40) @(posedge clk);

    // Reset asserted mid-CALC clears everything immediately.
    @(posedge clk);
    #1;
    bus.MulDivE = 1'b1;
    bus.funct3E = 3'b101;
    bus.RD1E    = 32'd1000;
    bus.RD2E    = 32'd9;
    bus.RdE     = 32'd30;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midreset_valid",  32'(bus.ValidMD), 32'd0);
    chk("midreset_result", bus.ResultMD, 32'd0);
    chk("midreset_rd",     bus.RdMD, 32'd0);
    chk("midreset_busy",   32'(bus.BusyMD), 32'd0);
    chk("midreset_stall",  32'(bus.StallMD), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.MulDivE = 1'b0;
    run_op(3'b000, 32'd6, 32'd7, 32'd31);
    @(posedge clk);
    #1 bus.MulDivE = 1'b0;

    // Randomized ops, occasionally separated by idle cycles.
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_opnd(), pick_opnd(), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1 bus.MulDivE = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    end
    @(posedge clk);
    #1 bus.MulDivE = 1'b0;
    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, consuming operands, `funct3E` and the destination tag straight out of the ID/EX pipeline register. A multi-cycle operation asserts a stall that freezes ID/EX and all earlier stages until the result is ready. The result is then presented for one cycle, qualified by `ValidMD`, for the EX-stage result mux to forward into EX/MEM.

## Interface
Parameters: none (fixed XLEN = 32).

Ports (`clk` and `reset` first). One clock; `reset` is asynchronous and active-low.
- `clk`  in  1  pipeline clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `MulDivE`  in  1  instruction in EX is an M-extension op
- `funct3E`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `RD1E`  in  32  rs1 operand (multiplicand/dividend)
- `RD2E`  in  32  rs2 operand (multiplier/divisor)
- `RdE`  in  32  destination tag, carried through unchanged
- `FlushE`  in  1  kill the op in EX
- `StallMD`  out  1  hold ID/EX and earlier stages
- `BusyMD`  out  1  unit not idle
- `ValidMD`  out  1  `ResultMD`/`RdMD` valid this cycle
- `ResultMD`  out  32  result
- `RdMD`  out  32  captured `RdE`

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE with `MulDivE`=1 and `FlushE`=0:
  - Capture `funct3E`, `RD1E`, `RD2E`, `RdE`.
  - Compute operand magnitudes and the result sign.
  - Load a 6-bit counter with 0.
  - Go to CALC, or directly to DONE for a special-case divide.
- CALC: one radix-2 step per cycle; the counter increments; after step 31 go to DONE.
  - Multiply: shift-add on unsigned magnitudes into a 64-bit accumulator.
  - Divide: restoring shift-subtract giving a 32-bit quotient and remainder.
- DONE: drive the result with `ValidMD`=1, then return to IDLE. `MulDivE` is ignored in DONE, because ID/EX still holds the finished instruction.
- Signedness:
  - MUL/MULH/DIV/REM treat both operands as signed.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - MULHU/DIVU/REMU treat both as unsigned.
- Sign fix applied in DONE:
  - The product is negated if the operand signs differ.
  - The quotient is negated if the signs differ.
  - The remainder takes the dividend's sign.
- Result selection: MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Special cases go IDLE→DONE with no CALC:
  - Divisor = 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF returns 0x80000000; the matching REM returns 0.
- `FlushE`=1 in any state:
  - Next state is IDLE; no `ValidMD` is produced for the killed op.
  - `FlushE` overrides a start in the same cycle.
- `reset` low (including mid-op): IDLE immediately; all registers are cleared.

## Timing
- Reset values: `ValidMD`=0, `ResultMD`=0, `RdMD`=0, `BusyMD`=0, `StallMD`=0, counter=0.
- `StallMD` is combinational: (IDLE & `MulDivE` & ~`FlushE`) | CALC. It is forced 0 while `reset` is low and is 0 in DONE.
- `BusyMD` = (state ≠ IDLE).
- Normal op, start cycle T (IDLE, `MulDivE`=1):
  - `StallMD`=1 during T..T+32 (CALC occupies T+1..T+32).
  - T+33 is DONE: `ValidMD`=1, `StallMD`=0, and ID/EX advances at the end of T+33.
  - Total EX occupancy is 34 cycles.
- Special-case divide: `StallMD`=1 in T only; DONE in T+1 (2 cycles total).
- Back-to-back M ops: the second op starts in the IDLE cycle T+34; there is no dead cycle beyond IDLE.
- `ValidMD`, `ResultMD` and `RdMD` are registered and stable for exactly the DONE cycle. `ValidMD` is 0 in every other cycle.

## Test plan
- MUL -7 × 3 (0xFFFFFFF9, 0x00000003) at cycle T → `StallMD` high T..T+32; at T+33 `ValidMD`=1, `ResultMD`=0xFFFFFFEB, `RdMD` equals the captured `RdE`.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2, each at T+33.
- Special cases, each with `ValidMD` at T+1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Abort: `FlushE` pulse in CALC cycle 10 → IDLE next cycle, `StallMD`=0, no `ValidMD`. `reset` low mid-CALC → all outputs 0 immediately; after release, a new MUL 6×7 → 42.
- Back-to-back MUL then DIVU with `MulDivE` held high in DONE → no restart in DONE; the second op starts at T+34; `ValidMD` pulses at T+33 and T+67.
